// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, signs fixed in a final cycle.
module mdu_hilo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mdu_start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] mdu_src_a,
  input  logic [WIDTH-1:0] mdu_src_b,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic             mdu_div_zero,
  output logic [WIDTH-1:0] mdu_hi,
  output logic [WIDTH-1:0] mdu_lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign signed_op = (mdu_op == OpMult) || (mdu_op == OpDiv);
  assign a_neg     = signed_op & mdu_src_a[WIDTH-1];
  assign b_neg     = signed_op & mdu_src_b[WIDTH-1];
  assign a_abs     = a_neg ? -mdu_src_a : mdu_src_a;
  assign b_abs     = b_neg ? -mdu_src_b : mdu_src_b;

  // Multiply: multiplier sits in the low half of acc and shifts out as the product shifts in.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: acc holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
  assign div_rem  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_rem - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mdu_start) begin
          case (mdu_op)
            OpMult, OpMultu: begin
              opnd_d    = a_abs;
              acc_d     = {{WIDTH{1'b0}}, b_abs};
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = 1'b0;
              is_div_d  = 1'b0;
              cnt_d     = '0;
              state_d   = StMul;
            end
            OpDiv, OpDivu: begin
              if (mdu_src_b == '0) begin
                hi_d = mdu_src_a;
                lo_d = '1;
                dz_d = 1'b1;
              end else begin
                opnd_d    = b_abs;
                acc_d     = {{WIDTH{1'b0}}, a_abs};
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                is_div_d  = 1'b1;
                cnt_d     = '0;
                state_d   = StDiv;
              end
            end
            OpMthi:  hi_d = mdu_src_a;
            OpMtlo:  lo_d = mdu_src_a;
            default: ;
          endcase
        end
      end
      StMul: begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StDiv: begin
        acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign mdu_busy     = (state_q != StIdle);
  assign mdu_done     = done_q;
  assign mdu_div_zero = dz_q;
  assign mdu_hi       = hi_q;
  assign mdu_lo       = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: stimulus pushes expected HI/LO, a negedge monitor pops on
// every done / div-zero pulse.
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mdu_start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] mdu_src_a = '0;
  logic [31:0] mdu_src_b = '0;
  logic        mdu_busy, mdu_done, mdu_div_zero;
  logic [31:0] mdu_hi, mdu_lo;

  mdu_hilo #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mdu_start    (mdu_start),
    .mdu_op       (mdu_op),
    .mdu_src_a    (mdu_src_a),
    .mdu_src_b    (mdu_src_b),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .mdu_div_zero (mdu_div_zero),
    .mdu_hi       (mdu_hi),
    .mdu_lo       (mdu_lo)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_done_seen = 0;
  int   n_done_exp  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (mdu_done || mdu_div_zero)) begin
      exp_t e;
      if (mdu_done) n_done_seen++;
      check("done_dz_exclusive", {63'd0, mdu_done & mdu_div_zero}, 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", {62'd0, mdu_done, mdu_div_zero}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("pulse_kind", {62'd0, mdu_done, mdu_div_zero}, {62'd0, ~e.dz, e.dz});
        check("hi", {32'd0, mdu_hi}, {32'd0, e.hi});
        check("lo", {32'd0, mdu_lo}, {32'd0, e.lo});
      end
    end
  end

  // Drive one start; returns #1 after the accepting edge with operands scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mdu_start = 1'b1;
    mdu_op    = op;
    mdu_src_a = a;
    mdu_src_b = b;
    @(posedge clk);
    #1;
    mdu_start = 1'b0;
    mdu_src_a = $urandom;
    mdu_src_b = $urandom;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mdu_busy) break;
      cycles++;
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    int cyc;
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = 1'b0;
    sb_q.push_back(e);
    n_done_exp++;
    issue(op, a, b);
    wait_idle(cyc);
    check("busy_cycles", 64'(cyc), 64'd33);
  endtask

  initial begin
    int   cyc;
    exp_t e;

    #1;
    check("rst_hi", {32'd0, mdu_hi}, 64'd0);
    check("rst_lo", {32'd0, mdu_lo}, 64'd0);
    check("rst_flags", {61'd0, mdu_busy, mdu_done, mdu_div_zero}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(OpMult,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(OpMultu, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB);
    run_op(OpDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(OpDivu,  32'd7,         32'd2,         32'd1,         32'd3);
    run_op(OpDiv,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
    run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Divide by zero: single-cycle, no busy.
    e.hi = 32'd5; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1;
    sb_q.push_back(e);
    issue(OpDivu, 32'd5, 32'd0);
    check("dz_busy", {63'd0, mdu_busy}, 64'd0);
    check("dz_hi_now", {32'd0, mdu_hi}, 64'd5);
    @(negedge clk);
    check("dz_busy_next", {63'd0, mdu_busy}, 64'd0);

    // MTHI then MTLO back to back.
    issue(OpMthi, 32'h1234_5678, 32'd0);
    check("mthi_hi", {32'd0, mdu_hi}, 64'h1234_5678);
    check("mthi_busy", {63'd0, mdu_busy}, 64'd0);
    issue(OpMtlo, 32'h9ABC_DEF0, 32'd0);
    check("mtlo_lo", {32'd0, mdu_lo}, 64'h9ABC_DEF0);
    check("mtlo_hi", {32'd0, mdu_hi}, 64'h1234_5678);
    check("mtlo_busy", {63'd0, mdu_busy}, 64'd0);

    // MULTU 3x4 with a DIVU start held high throughout the busy window.
    e.hi = 32'd0; e.lo = 32'd12; e.dz = 1'b0;
    sb_q.push_back(e);
    n_done_exp++;
    issue(OpMultu, 32'd3, 32'd4);
    mdu_start = 1'b1;
    mdu_op    = OpDivu;
    mdu_src_a = 32'd7;
    mdu_src_b = 32'd2;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!mdu_busy) break;
      cyc++;
      if (cyc == 15) begin
        check("hold_hi", {32'd0, mdu_hi}, 64'h1234_5678);
        check("hold_lo", {32'd0, mdu_lo}, 64'h9ABC_DEF0);
      end
    end
    mdu_start = 1'b0;
    check("busy_start_cycles", 64'(cyc), 64'd33);
    @(negedge clk);
    check("busy_start_ignored", {63'd0, mdu_busy}, 64'd0);

    // Reset abort at iteration 10.
    issue(OpMult, 32'd5, 32'hFFFF_FFFA);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_hi", {32'd0, mdu_hi}, 64'd0);
    check("abort_lo", {32'd0, mdu_lo}, 64'd0);
    check("abort_busy", {63'd0, mdu_busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_idle", {63'd0, mdu_busy}, 64'd0);

    check("done_count", 64'(n_done_seen), 64'(n_done_exp));
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execute stage of the MIPS datapath. It takes the same rs/rt operands that feed the ALU and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. Its HI/LO outputs feed the writeback mux next to `alu_result` for MFHI/MFLO. The controller stalls the PC while `mdu_busy` is high.

## Interface
- `WIDTH`, 32, operand width. Only 32 is supported.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `mdu_start` in 1: launch request for `mdu_op`. Sampled at each rising edge.
- `mdu_op` in 3: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO. Codes 6 and 7 are no-ops.
- `mdu_src_a` in 32: rs operand (multiplicand / dividend / MTHI-MTLO source).
- `mdu_src_b` in 32: rt operand (multiplier / divisor).
- `mdu_busy` out 1: multi-cycle operation in progress.
- `mdu_done` out 1: one-cycle pulse, high in the cycle after HI/LO take a MULT/DIV result.
- `mdu_div_zero` out 1: one-cycle pulse, high after a DIV/DIVU with divisor 0.
- `mdu_hi` out 32: HI register.
- `mdu_lo` out 32: LO register.

## Operation
- **FSM states:** IDLE, MUL, DIV, FIX.
  - Every register is reset asynchronously by `rst_n` low.
  - Reset values: `mdu_hi`=0, `mdu_lo`=0, `mdu_busy`=0, `mdu_done`=0, `mdu_div_zero`=0, state=IDLE, iteration counter=0.
- **Accept rule:** a start is accepted only when `mdu_start`=1 and state=IDLE.
  - A start while busy is ignored completely; no queueing, and no HI/LO or flag change.
- **MTHI / MTLO:** write `mdu_src_a` into HI / LO at the accepting edge. State stays IDLE and busy stays 0.
- **MULT / DIV accept:**
  - Latch |a| and |b| (absolute values for the signed ops, raw values for the unsigned ops).
  - Latch the result-sign flags, clear the counter, and go to MUL or DIV.
  - Set busy=1.
- **MUL:** radix-2 shift-add on a 64-bit accumulator, one bit per cycle, 32 iterations. After iteration 32, go to FIX.
- **DIV:** restoring division, one quotient bit per cycle, 32 iterations. After iteration 32, go to FIX.
- **FIX:** apply the signs and write the result, then return to IDLE with busy=0 and `mdu_done`=1 for one cycle.
  - MULT: negate the 64-bit product if the operand signs differ. HI gets the upper 32 bits, LO the lower 32 bits.
  - DIV: negate the quotient if the operand signs differ. The remainder takes the sign of the dividend. LO=quotient, HI=remainder.
  - Unsigned ops: no sign fix.
- **Divide by zero (DIV/DIVU with b=0):** no iterations run and busy never rises. At the accepting edge:
  - HI ← `mdu_src_a`.
  - LO ← 0xFFFFFFFF.
  - `mdu_div_zero`=1 for the next cycle.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and needs no special-case logic.
- **HI/LO hold rule:** HI and LO hold their previous values throughout MUL/DIV. They change only in FIX, on MTHI/MTLO, on divide-by-zero, or on reset.
- **Reset mid-operation:** the operation is aborted, all outputs return to their reset values, and the partial result is discarded.

## Timing
- Let E0 be the accepting edge of a MULT/DIV.
  - `mdu_busy` is high from after E0 through E33.
  - Iterations occur on edges E1..E32.
  - The FIX write occurs at E33. HI/LO show the new values after E33, and busy falls at the same time.
  - `mdu_done` is high for exactly the cycle between E33 and E34.
- Total latency is 33 cycles from acceptance to result.
- Back-to-back operation: a new start is accepted at E34 at the earliest (or at E33 if IDLE is reached combinationally). It is decided as E34: the unit must be IDLE when sampled.
- MTHI/MTLO and divide-by-zero have 1-cycle latency, and back-to-back issue is allowed every cycle.
- `mdu_done` and `mdu_div_zero` are never high together.
- Operand inputs are ignored after E0. The upstream may change them freely while busy.

## Test plan
- **Unsigned multiply:** reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF.
  - HI=0xFFFFFFFE, LO=0x00000001 after E33.
  - busy high for exactly 33 cycles, `mdu_done` a single pulse.
- **Signed multiply:** MULT 0xFFFFFFFD (−3) × 7.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Then MULTU 0xFFFFFFFD × 7: HI=0x00000006, LO=0xFFFFFFEB.
- **Signed vs unsigned divide:** DIV 0xFFFFFFF9 (−7) / 2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIVU 7 / 2 gives LO=3, HI=1.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- **Divide by zero:** DIVU 5 / 0.
  - HI=5, LO=0xFFFFFFFF one edge after the start.
  - `mdu_div_zero` high for one cycle, busy stays 0, `mdu_done` stays 0.
- **Busy-start, reset abort, MTHI/MTLO:**
  1. MTHI 0x12345678, then MTLO 0x9ABCDEF0 on the next cycle: HI and LO are updated and busy stays 0 throughout.
  2. Start MULTU 3 × 4, and hold `mdu_start` high with DIVU during the busy window. The DIVU is ignored, and the result is HI=0, LO=12.
  3. Start a new MULT, assert `rst_n` low at iteration 10: HI=LO=0, busy=0 immediately, and no `mdu_done` follows.
